// File: rtl/adder_share_arb_pkg.sv
// Shared types and widths for the adder_share_arb round-robin adder arbiter.
package adder_share_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned RES_W_DEFAULT = DW_DEFAULT + 1;
  localparam int unsigned STATS_W       = 16;

  // Result width carries the adder's carry-out bit.
  function automatic int unsigned res_w(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win_idx,
  output logic            any_grant
);

  int best;
  int off;

  // Pick the valid requester with the smallest rotational distance from ptr.
  always_comb begin
    best      = int'(NREQ);
    off       = 0;
    win_idx   = '0;
    any_grant = 1'b0;
    grant     = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (req_valid[j]) begin
        off = (j + int'(NREQ) - int'(ptr)) % int'(NREQ);
        if (off < best) begin
          best      = off;
          win_idx   = IDW'(j);
          any_grant = 1'b1;
        end
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      grant[j] = any_grant && (win_idx == IDW'(j));
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder among NREQ requesters with a one-entry response slot.
// Optional grant counter port enabled by ADDER_SHARE_ARB_STATS_EN.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [DW:0]          rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready
`ifdef ADDER_SHARE_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]   grant_cnt
`endif
);

  localparam int unsigned RES_W = res_w(DW);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [RES_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     win_idx;
  logic               any_grant;
  logic               slot_free;
  logic               accept;
  logic [DW-1:0]      a_sel;
  logic [DW-1:0]      b_sel;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .win_idx   (win_idx),
    .any_grant (any_grant)
  );

  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  assign accept    = slot_free && !rst && any_grant;
  assign req_ready = (slot_free && !rst) ? grant : '0;

  // Operand mux for the winning requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_idx == IDW'(i)) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
      end
    end
  end

  // Slot FSM, pointer advance and response capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rsp_sum_d = rsp_sum_q;
    rsp_id_d  = rsp_id_q;
    if (accept) begin
      state_d   = ST_FULL;
      rsp_sum_d = RES_W'(a_sel) + RES_W'(b_sel);
      rsp_id_d  = win_idx;
      ptr_d     = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb (NREQ=4, DW=8, IDW=2).
module tb_adder_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [DW:0]         rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;
`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [15:0]         grant_cnt;
`endif

  int n_total;
  int n_pass;

  // Hand-computed sums for operand set a=0x10*(i+1), b=i+3.
  logic [8:0] rr_sum [4];
  logic [3:0] rr_grant [4];

  adder_share_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef ADDER_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic set_rr_ops();
    for (int i = 0; i < 4; i++) begin
      set_op(i, 8'(8'h10 * (i + 1)), 8'(i + 3));
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rr_sum[0] = 9'h013; rr_sum[1] = 9'h024; rr_sum[2] = 9'h035; rr_sum[3] = 9'h046;
    rr_grant[0] = 4'b0001; rr_grant[1] = 4'b0010; rr_grant[2] = 4'b0100; rr_grant[3] = 4'b1000;

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("reset_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("reset_rsp_sum",   16'(rsp_sum),   16'h0);
    chk("reset_rsp_id",    16'(rsp_id),    16'h0);
    chk("reset_req_ready", 16'(req_ready), 16'h0);

    // Single request from requester 2.
    rst       = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 8'h12, 8'h34);
    #1;
    chk("single_ready", 16'(req_ready), 16'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_valid", 16'(rsp_valid), 16'h1);
    chk("single_sum",   16'(rsp_sum),   16'h046);
    chk("single_id",    16'(rsp_id),    16'h2);

    // Overflow: 0xFF + 0xFF from requester 0 while draining previous response.
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    set_op(0, 8'hFF, 8'hFF);
    #1;
    chk("ovf_ready", 16'(req_ready), 16'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("ovf_sum",   16'(rsp_sum), 16'h1FE);
    chk("ovf_bit8",  16'(rsp_sum[8]), 16'h1);
    chk("ovf_id",    16'(rsp_id), 16'h0);
    tick();
    chk("drain_valid", 16'(rsp_valid), 16'h0);
    chk("drain_sum_hold", 16'(rsp_sum), 16'h1FE);

    // Round robin from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rr_ops();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 16'(req_ready), 16'(rr_grant[k % 4]));
      tick();
      chk("rr_valid", 16'(rsp_valid), 16'h1);
      chk("rr_id",    16'(rsp_id),    16'(k % 4));
      chk("rr_sum",   16'(rsp_sum),   16'(rr_sum[k % 4]));
    end

    // Backpressure: slot holds requester 1's result, ptr=2.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 16'(req_ready), 16'h0);
      chk("bp_sum",   16'(rsp_sum),   16'h024);
      chk("bp_id",    16'(rsp_id),    16'h1);
      tick();
    end
    set_op(1, 8'h80, 8'h7F);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(req_ready), 16'h2);
    tick();
    chk("bp_new_valid", 16'(rsp_valid), 16'h1);
    chk("bp_new_sum",   16'(rsp_sum),   16'h0FF);
    chk("bp_new_id",    16'(rsp_id),    16'h1);

    // Reset mid-operation with ptr=3 and a pending response.
    set_rr_ops();
    req_valid = 4'b0100;
    #1;
    chk("mid_pre_ready", 16'(req_ready), 16'h4);
    tick();
    chk("mid_pre_valid", 16'(rsp_valid), 16'h1);
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready", 16'(req_ready), 16'h0);
    tick();
    chk("mid_rst_valid", 16'(rsp_valid), 16'h0);
    rst = 1'b0;
    #1;
    chk("mid_first_grant", 16'(req_ready), 16'h1);
    tick();
    chk("mid_first_id",  16'(rsp_id),  16'h0);
    chk("mid_first_sum", 16'(rsp_sum), 16'h013);

    // Idle cycles leave the pointer at 1.
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_valid", 16'(rsp_valid), 16'h0);
    req_valid = 4'b1111;
    #1;
    chk("idle_ptr_grant", 16'(req_ready), 16'h2);

`ifdef ADDER_SHARE_ARB_STATS_EN
    rst = 1'b1;
    tick();
    chk("stats_reset", 16'(grant_cnt), 16'h0);
    rst       = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("stats_wrap", 16'(grant_cnt), 16'd4464);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
